// File: rtl/memory_stage_stack_if.sv
// rtl/memory_stage_stack_if.sv - EX/MEM-side request and MEM/WB-side result bundle for memory_stage_stack
interface memory_stage_stack_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11,
   parameter int REG_AW = 3
) ();
   logic [DATA_W-1:0]   alu_result;
   logic [DATA_W-1:0]   rsrc_value;
   logic [DATA_W-1:0]   rdst_value;
   logic [REG_AW-1:0]   rdst_address;
   logic                mem_read;
   logic                mem_write;
   logic                wb;
   logic                push;
   logic                pop;
   logic                wide;
   logic [2*DATA_W-1:0] wide_data;
   logic                stall;
   logic [ADDR_W-1:0]   sp_out;
   logic                stack_fault;
   logic [DATA_W-1:0]   data_from_memory;
   logic [DATA_W-1:0]   memwb_alu_result;
   logic [REG_AW-1:0]   memwb_rdst_address;
   logic                memwb_mem_read;
   logic                memwb_wb;
   logic [2*DATA_W-1:0] memwb_wide_data;

   modport master (
      output alu_result, rsrc_value, rdst_value, rdst_address, mem_read, mem_write,
             wb, push, pop, wide, wide_data,
      input  stall, sp_out, stack_fault, data_from_memory, memwb_alu_result,
             memwb_rdst_address, memwb_mem_read, memwb_wb, memwb_wide_data
   );

   modport slave (
      input  alu_result, rsrc_value, rdst_value, rdst_address, mem_read, mem_write,
             wb, push, pop, wide, wide_data,
      output stall, sp_out, stack_fault, data_from_memory, memwb_alu_result,
             memwb_rdst_address, memwb_mem_read, memwb_wb, memwb_wide_data
   );
endinterface

// File: rtl/memory_stage_stack.sv
// rtl/memory_stage_stack.sv - memory stage with data RAM, hardware stack pointer and MEM/WB register
module memory_stage_stack #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 11,
   parameter int                REG_AW   = 3,
   parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   memory_stage_stack_if.slave bus
);
   typedef enum logic {S_IDLE, S_WIDE2} state_t;

   localparam logic [ADDR_W-1:0] SP_MAX = {ADDR_W{1'b1}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   sp_q, sp_d;
   logic                fault_q;
   logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0]   lo_q, data_q;
   logic [2*DATA_W-1:0] wide_q;
   logic [DATA_W-1:0]   mw_alu_q, mw_alu_d;
   logic [REG_AW-1:0]   mw_rdst_q, mw_rdst_d;
   logic                mw_mr_q, mw_mr_d, mw_wb_q, mw_wb_d;
   logic [DATA_W-1:0]   op_alu_q;
   logic [REG_AW-1:0]   op_rdst_q;
   logic                op_wb_q, op_pop_q;

   logic                is_load, is_store, is_push, is_pop, fault_c;
   logic [ADDR_W-1:0]   n_c, waddr_c, raddr_c;
   logic [DATA_W-1:0]   wdata_c;
   logic                we_c, stall_c, fault_set_c, rd_data_c, ld_lo_c, lo_from_mem_c;
   logic                fin_pop_c, latch_op_c;

   // Conflicting or unqualified request combinations decode to no access at all.
   assign is_push  = bus.mem_write & bus.push & ~bus.mem_read & ~bus.pop;
   assign is_pop   = bus.mem_read & bus.pop & ~bus.mem_write & ~bus.push;
   assign is_load  = bus.mem_read & ~bus.mem_write & ~bus.push & ~bus.pop;
   assign is_store = bus.mem_write & ~bus.mem_read & ~bus.push & ~bus.pop;
   assign n_c      = bus.wide ? ADDR_W'(2) : ADDR_W'(1);
   assign fault_c  = (is_push & (sp_q < n_c)) | (is_pop & (sp_q > (SP_MAX - n_c)));

   always_comb begin
      state_d       = state_q;
      sp_d          = sp_q;
      stall_c       = 1'b0;
      fault_set_c   = 1'b0;
      we_c          = 1'b0;
      waddr_c       = sp_q;
      wdata_c       = bus.rsrc_value;
      raddr_c       = bus.rsrc_value[ADDR_W-1:0];
      rd_data_c     = 1'b0;
      ld_lo_c       = 1'b0;
      lo_from_mem_c = 1'b0;
      fin_pop_c     = 1'b0;
      latch_op_c    = 1'b0;
      mw_alu_d      = bus.alu_result;
      mw_rdst_d     = bus.rdst_address;
      mw_wb_d       = bus.wb;
      mw_mr_d       = is_load | is_pop;
      case (state_q)
         S_IDLE: begin
            if (fault_c) begin
               fault_set_c = 1'b1;
               mw_wb_d     = 1'b0;
               mw_mr_d     = 1'b0;
            end else if (bus.wide && (is_push || is_pop)) begin
               // First half of a wide op: MEM/WB takes a bubble, op fields are latched.
               stall_c    = 1'b1;
               state_d    = S_WIDE2;
               latch_op_c = 1'b1;
               ld_lo_c    = 1'b1;
               mw_alu_d   = mw_alu_q;
               mw_rdst_d  = mw_rdst_q;
               mw_wb_d    = 1'b0;
               mw_mr_d    = 1'b0;
               if (is_push) begin
                  we_c    = 1'b1;
                  wdata_c = bus.wide_data[2*DATA_W-1:DATA_W];
               end else begin
                  lo_from_mem_c = 1'b1;
                  raddr_c       = sp_q + ADDR_W'(1);
               end
            end else if (is_push) begin
               we_c = 1'b1;
               sp_d = sp_q - ADDR_W'(1);
            end else if (is_pop) begin
               raddr_c   = sp_q + ADDR_W'(1);
               rd_data_c = 1'b1;
               sp_d      = sp_q + ADDR_W'(1);
            end else if (is_store) begin
               we_c    = 1'b1;
               waddr_c = bus.rdst_value[ADDR_W-1:0];
            end else if (is_load) begin
               rd_data_c = 1'b1;
            end
         end
         S_WIDE2: begin
            state_d   = S_IDLE;
            mw_alu_d  = op_alu_q;
            mw_rdst_d = op_rdst_q;
            mw_wb_d   = op_wb_q;
            mw_mr_d   = op_pop_q;
            if (op_pop_q) begin
               raddr_c   = sp_q + ADDR_W'(2);
               fin_pop_c = 1'b1;
               sp_d      = sp_q + ADDR_W'(2);
            end else begin
               we_c    = 1'b1;
               waddr_c = sp_q - ADDR_W'(1);
               wdata_c = lo_q;
               sp_d    = sp_q - ADDR_W'(2);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we_c) mem[waddr_c] <= wdata_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sp_q      <= SP_RESET;
         fault_q   <= 1'b0;
         lo_q      <= '0;
         data_q    <= '0;
         wide_q    <= '0;
         mw_alu_q  <= '0;
         mw_rdst_q <= '0;
         mw_mr_q   <= 1'b0;
         mw_wb_q   <= 1'b0;
         op_alu_q  <= '0;
         op_rdst_q <= '0;
         op_wb_q   <= 1'b0;
         op_pop_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sp_q      <= sp_d;
         fault_q   <= fault_q | fault_set_c;
         mw_alu_q  <= mw_alu_d;
         mw_rdst_q <= mw_rdst_d;
         mw_mr_q   <= mw_mr_d;
         mw_wb_q   <= mw_wb_d;
         if (latch_op_c) begin
            op_alu_q  <= bus.alu_result;
            op_rdst_q <= bus.rdst_address;
            op_wb_q   <= bus.wb;
            op_pop_q  <= is_pop;
         end
         if (ld_lo_c) lo_q <= lo_from_mem_c ? mem[raddr_c] : bus.wide_data[DATA_W-1:0];
         if (fin_pop_c) begin
            wide_q <= {mem[raddr_c], lo_q};
            data_q <= lo_q;
         end else if (rd_data_c) begin
            data_q <= mem[raddr_c];
         end
      end
   end

   assign bus.stall              = stall_c & rst_n;
   assign bus.sp_out             = sp_q;
   assign bus.stack_fault        = fault_q;
   assign bus.data_from_memory   = data_q;
   assign bus.memwb_alu_result   = mw_alu_q;
   assign bus.memwb_rdst_address = mw_rdst_q;
   assign bus.memwb_mem_read     = mw_mr_q;
   assign bus.memwb_wb           = mw_wb_q;
   assign bus.memwb_wide_data    = wide_q;
endmodule
